// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte handshake for the shared UART transmitter.
// Requesters hold req with their byte until the one-cycle ack.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   ack;

  modport master (
    output req,
    output req_data,
    input  ack
  );

  modport slave (
    input  req,
    input  req_data,
    output ack
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one 8N1 UART transmitter.
// Bits advance on clk_bps pulses from an external baud generator.
module uart_tx_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.slave  bus,
  output logic              bps_start,
  input  logic              clk_bps,
  output logic              txd,
  output logic              busy,
  output logic [2:0]        grant_id
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    STOP,
    GAP
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       sr_q, sr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [2:0]       last_q, last_d;
  logic [2:0]       gid_q, gid_d;
  logic             txd_q, txd_d;
  logic             bps_q, bps_d;
  logic             busy_q, busy_d;
  logic [N_REQ-1:0] ack_q, ack_d;

  logic [7:0]       req8;
  logic [63:0]      data64;
  logic [7:0]       ack8;
  logic [2:0]       idx;
  logic [2:0]       pick;
  logic             pick_vld;

  assign req8   = 8'(bus.req);
  assign data64 = 64'(bus.req_data);
  assign ack8   = 8'b1 << pick;

  // First set bit strictly after the last grantee, wrapping.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    idx      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = 3'((int'(last_q) + k) % N_REQ);
      if (!pick_vld && req8[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      last_q  <= 3'(N_REQ - 1);
      gid_q   <= '0;
      txd_q   <= 1'b1;
      bps_q   <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      txd_q   <= txd_d;
      bps_q   <= bps_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (pick_vld) state_d = SHIFT;
      SHIFT: if (clk_bps && cnt_q == 4'd8) state_d = STOP;
      STOP:  if (clk_bps) state_d = GAP;
      GAP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    last_d = last_q;
    gid_d  = gid_q;
    txd_d  = txd_q;
    bps_d  = bps_q;
    busy_d = busy_q;
    ack_d  = '0;
    unique case (state_q)
      IDLE: begin
        txd_d  = 1'b1;
        bps_d  = 1'b0;
        busy_d = 1'b0;
        if (pick_vld) begin
          sr_d   = data64[{pick, 3'b000} +: 8];
          ack_d  = ack8[N_REQ-1:0];
          gid_d  = pick;
          last_d = pick;
          txd_d  = 1'b0;
          bps_d  = 1'b1;
          busy_d = 1'b1;
          cnt_d  = '0;
        end
      end
      SHIFT: begin
        if (clk_bps) begin
          if (cnt_q == 4'd8) begin
            txd_d = 1'b1;
          end else begin
            txd_d = sr_q[0];
            sr_d  = sr_q >> 1;
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      STOP: begin
        if (clk_bps) begin
          bps_d  = 1'b0;
          busy_d = 1'b0;
        end
      end
      GAP: begin
        // Holding bps_start low here lets the baud counter clear.
        txd_d  = 1'b1;
        bps_d  = 1'b0;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.ack   = ack_q;
  assign bps_start = bps_q;
  assign txd       = txd_q;
  assign busy      = busy_q;
  assign grant_id  = gid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table of grants plus
// hand-written reset, withdraw and idle-tick sequences.
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_bps;
  logic       bps_start;
  logic       txd;
  logic       busy;
  logic [2:0] grant_id;

  uart_tx_arbiter_if #(.N_REQ(4)) bus ();

  uart_tx_arbiter #(.N_REQ(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .bps_start (bps_start),
    .clk_bps   (clk_bps),
    .txd       (txd),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] id;
    logic [7:0] b;
  } exp_t;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [1:0]  id;
    logic [7:0]  b;
  } vec_t;

  exp_t sb[$];
  vec_t vt[12];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   ack_seen[4];
  int   exp_ack[4];
  int   snap;

  initial begin
    for (int i = 0; i < 4; i++) begin
      ack_seen[i] = 0;
      exp_ack[i]  = 0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++)
      if (bus.ack[i]) ack_seen[i]++;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic post(input logic [3:0] r, input logic [31:0] d,
                      input logic [1:0] id, input logic [7:0] b);
    exp_t e;
    bus.req      = r;
    bus.req_data = d;
    e.id = id;
    e.b  = b;
    sb.push_back(e);
  endtask

  // lat: expected negedges from post to ack (0 = unchecked)
  // np: clk_bps pulses to issue; wd: raise/drop req[1] mid-frame
  task automatic run_frame(input int lat, input int spc,
                           input bit wd, input int np);
    exp_t       e;
    int         w;
    bit         got;
    logic [3:0] oh;
    logic [7:0] sh;
    if (sb.size() == 0) begin
      check("sb_empty", 32'(sb.size()), 32'd1);
      return;
    end
    e   = sb.pop_front();
    w   = 0;
    got = 1'b0;
    while (!got && w < 20) begin
      @(negedge clk);
      w++;
      if (bus.ack != 4'b0) got = 1'b1;
    end
    if (!got) begin
      check("ack_timeout", 32'd0, 32'd1);
      return;
    end
    exp_ack[e.id]++;
    oh = 4'b0001 << e.id;
    if (lat > 0) check("grant_lat", 32'(w), 32'(lat));
    check("ack_onehot", 32'(bus.ack), 32'(oh));
    check("grant_id", 32'(grant_id), 32'(e.id));
    check("start_bit", 32'({txd, bps_start, busy}), 32'b011);
    @(negedge clk);
    check("ack_pulse", 32'(bus.ack), 32'd0);
    bus.req[e.id] = 1'b0;
    for (int p = 0; p < np; p++) begin
      if (wd && p == 3) bus.req[1] = 1'b1;
      if (wd && p == 6) bus.req[1] = 1'b0;
      repeat (spc - 1) @(negedge clk);
      clk_bps = 1'b1;
      @(negedge clk);
      clk_bps = 1'b0;
      sh = e.b >> p;
      check("txd_bit", 32'(txd), (p < 8) ? 32'(sh[0]) : 32'd1);
      if (p == 9)
        check("frame_end", 32'({bps_start, busy}), 32'b00);
      else
        check("frame_mid", 32'({bps_start, busy}), 32'b11);
    end
  endtask

  initial begin
    vt[0]  = '{4'b0001, 32'h000000A5, 2'd0, 8'hA5};
    vt[1]  = '{4'b1111, 32'h13121110, 2'd1, 8'h11};
    vt[2]  = '{4'b1111, 32'h13121110, 2'd2, 8'h12};
    vt[3]  = '{4'b1111, 32'h13121110, 2'd3, 8'h13};
    vt[4]  = '{4'b1111, 32'h13121110, 2'd0, 8'h10};
    vt[5]  = '{4'b0100, 32'h00C30000, 2'd2, 8'hC3};
    vt[6]  = '{4'b0101, 32'h00FF0000, 2'd0, 8'h00};
    vt[7]  = '{4'b0101, 32'h00FF0000, 2'd2, 8'hFF};
    vt[8]  = '{4'b1000, 32'h5A000000, 2'd3, 8'h5A};
    vt[9]  = '{4'b0010, 32'h00003C00, 2'd1, 8'h3C};
    vt[10] = '{4'b0011, 32'h00009E81, 2'd0, 8'h81};
    vt[11] = '{4'b0011, 32'h00009E81, 2'd1, 8'h9E};

    rst          = 1'b1;
    clk_bps      = 1'b0;
    bus.req      = '0;
    bus.req_data = '0;
    repeat (3) @(negedge clk);
    check("rst_lines", 32'({txd, bps_start, busy}), 32'b100);
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_gid", 32'(grant_id), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      clk_bps = 1'b1;
      @(negedge clk);
      clk_bps = 1'b0;
      @(negedge clk);
      check("idle_tick", 32'({txd, bps_start, busy, bus.ack}),
            32'b100_0000);
    end

    // First frame sees bit ticks every 16 cycles; the rest every 4.
    for (int i = 0; i < 12; i++) begin
      post(vt[i].req, vt[i].data, vt[i].id, vt[i].b);
      run_frame((i == 0) ? 1 : 2, (i == 0) ? 16 : 4, 1'b0, 10);
    end

    snap = ack_seen[1];
    post(4'b0001, 32'h00000077, 2'd0, 8'h77);
    run_frame(2, 4, 1'b1, 10);
    repeat (12) @(negedge clk);
    check("withdraw_ack", 32'(ack_seen[1]), 32'(snap));
    check("withdraw_idle", 32'({txd, bps_start, busy}), 32'b100);

    post(4'b0100, 32'h00C70000, 2'd2, 8'hC7);
    run_frame(1, 4, 1'b0, 4);
    bus.req = 4'b0100;
    rst     = 1'b1;
    @(negedge clk);
    check("midrst_lines", 32'({txd, bps_start, busy}), 32'b100);
    check("midrst_ack", 32'(bus.ack), 32'd0);
    check("midrst_gid", 32'(grant_id), 32'd0);
    @(negedge clk);
    check("rst_req_ack", 32'(bus.ack), 32'd0);
    rst = 1'b0;
    post(4'b1010, 32'h5A00E100, 2'd1, 8'hE1);
    run_frame(1, 4, 1'b0, 10);
    post(4'b1000, 32'h5A000000, 2'd3, 8'h5A);
    run_frame(2, 4, 1'b0, 10);

    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++)
      check("ack_count", 32'(ack_seen[i]), 32'(exp_ack[i]));
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
